// File: rtl/ber_ctrl_pkg.sv
// Shared types and default constants for the BER test controller.
package ber_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    MEASURE,
    DONE
  } ber_state_e;

  localparam int unsigned DEF_LOAD_CYCLES  = 4;
  localparam int unsigned DEF_SETTLE_WRAPS = 2;
  localparam int unsigned DEF_WIN_LOG2     = 20;
  localparam int unsigned DEF_ERR_W        = 22;
  localparam int unsigned DEF_ERR_THRESH   = 0;

  // True while a test sequence is in progress
  function automatic logic ber_busy(input ber_state_e s);
    return (s == LOAD) || (s == SETTLE) || (s == MEASURE);
  endfunction

endpackage

// File: rtl/ber_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag.
module ber_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Count up to all ones; an increment at the ceiling only raises sat
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc) begin
      if (count == CNT_MAX) begin
        sat <= 1'b1;
      end else begin
        count <= count + W'(1);
      end
    end
  end

endmodule

// File: rtl/ber_test_controller.sv
// BER test sequencer: loads the LFSR, clears the magnitude accumulator, waits
// for the reference level to settle, then counts symbols and errors over a
// fixed window and holds the result until restarted.
// Optional feature macro: BER_THRESH_EN adds the registered ber_pass output.
module ber_test_controller
  import ber_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES  = DEF_LOAD_CYCLES,
  parameter int unsigned SETTLE_WRAPS = DEF_SETTLE_WRAPS,
  parameter int unsigned WIN_LOG2     = DEF_WIN_LOG2,
  parameter int unsigned ERR_W        = DEF_ERR_W,
  parameter int unsigned ERR_THRESH   = DEF_ERR_THRESH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                sym_clk_ena,
  input  logic                lfsr_wrap,
  input  logic                sym_correct,
  input  logic                sym_error,
  output logic                load_data,
  output logic                clear_accumulator,
  output logic                busy,
  output logic                measuring,
  output logic                done,
  output logic [WIN_LOG2:0]   sym_count,
  output logic [ERR_W-1:0]    err_count,
  output logic                err_sat,
  output logic                proto_err
`ifdef BER_THRESH_EN
  ,
  output logic                ber_pass
`endif
);

  localparam int unsigned LCW = $clog2(LOAD_CYCLES + 1);
  localparam int unsigned WCW = $clog2(SETTLE_WRAPS + 1);
  localparam int unsigned SCW = WIN_LOG2 + 1;

  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYCLES - 1);
  localparam logic [WCW-1:0] WRAP_LAST = WCW'(SETTLE_WRAPS - 1);
  localparam logic [SCW-1:0] SYM_LAST  = SCW'((64'd1 << WIN_LOG2) - 64'd1);

  // Elaboration-time parameter sanity
  if (LOAD_CYCLES < 1) begin : g_bad_load_cycles
    $error("LOAD_CYCLES must be at least 1");
  end
  if (SETTLE_WRAPS < 1) begin : g_bad_settle_wraps
    $error("SETTLE_WRAPS must be at least 1");
  end
  if (64'(ERR_THRESH) >= (64'd1 << ERR_W)) begin : g_bad_err_thresh
    $error("ERR_THRESH does not fit in ERR_W bits");
  end

  ber_state_e     state;
  logic [LCW-1:0] load_cnt;
  logic [WCW-1:0] wrap_cnt;
  logic           start_q;

  logic busy_st_c;
  logic meas_entry_c;
  logic err_inc_c;

  assign busy_st_c    = ber_busy(state);
  assign meas_entry_c = (state == SETTLE) && lfsr_wrap && (wrap_cnt == WRAP_LAST) && !abort;
  assign err_inc_c    = (state == MEASURE) && sym_clk_ena && sym_error && !abort;

  // Error counter: cleared on measurement entry, saturates at all ones
  ber_sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (meas_entry_c),
    .inc   (err_inc_c),
    .count (err_count),
    .sat   (err_sat)
  );

`ifdef BER_THRESH_EN
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [ERR_W-1:0] err_cnt_nxt_c;
  logic             err_sat_nxt_c;
  logic             pass_nxt_c;

  // Verdict from the error state as it will stand after the closing symbol
  always_comb begin
    err_cnt_nxt_c = err_count;
    err_sat_nxt_c = err_sat;
    if (err_inc_c) begin
      if (err_count == ERR_MAX) begin
        err_sat_nxt_c = 1'b1;
      end else begin
        err_cnt_nxt_c = err_count + ERR_W'(1);
      end
    end
    pass_nxt_c = (err_cnt_nxt_c <= ERR_W'(ERR_THRESH)) && !err_sat_nxt_c;
  end
`endif

  // Sequencer state, strobes and window counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      load_cnt          <= '0;
      wrap_cnt          <= '0;
      start_q           <= 1'b0;
      load_data         <= 1'b0;
      clear_accumulator <= 1'b0;
      busy              <= 1'b0;
      measuring         <= 1'b0;
      done              <= 1'b0;
      sym_count         <= '0;
      proto_err         <= 1'b0;
`ifdef BER_THRESH_EN
      ber_pass          <= 1'b0;
`endif
    end else begin
      start_q           <= start;
      done              <= 1'b0;
      clear_accumulator <= lfsr_wrap && busy_st_c;
      if (abort) begin
        state             <= IDLE;
        load_data         <= 1'b0;
        busy              <= 1'b0;
        measuring         <= 1'b0;
        clear_accumulator <= 1'b0;
`ifdef BER_THRESH_EN
        ber_pass          <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= LOAD;
              load_data <= 1'b1;
              busy      <= 1'b1;
              load_cnt  <= '0;
            end
          end
          LOAD: begin
            if (load_cnt == LOAD_LAST) begin
              state             <= SETTLE;
              load_data         <= 1'b0;
              clear_accumulator <= 1'b1;
              wrap_cnt          <= '0;
            end else begin
              load_cnt <= load_cnt + LCW'(1);
            end
          end
          SETTLE: begin
            if (lfsr_wrap) begin
              if (wrap_cnt == WRAP_LAST) begin
                state     <= MEASURE;
                measuring <= 1'b1;
                sym_count <= '0;
                proto_err <= 1'b0;
              end else begin
                wrap_cnt <= wrap_cnt + WCW'(1);
              end
            end
          end
          MEASURE: begin
            if (sym_clk_ena) begin
              sym_count <= sym_count + SCW'(1);
              if (sym_correct == sym_error) begin
                proto_err <= 1'b1;
              end
              if (sym_count == SYM_LAST) begin
                state     <= DONE;
                busy      <= 1'b0;
                measuring <= 1'b0;
                done      <= 1'b1;
`ifdef BER_THRESH_EN
                ber_pass  <= pass_nxt_c;
`endif
              end
            end
          end
          DONE: begin
            if (start && !start_q) begin
              state     <= LOAD;
              load_data <= 1'b1;
              busy      <= 1'b1;
              load_cnt  <= '0;
`ifdef BER_THRESH_EN
              ber_pass  <= 1'b0;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ber_test_controller.sv
// Scoreboard bench for ber_test_controller with a small window (16 symbols)
// and a 2-bit error counter so saturation is reachable.
module tb_ber_test_controller;

  localparam int unsigned LOAD_CYCLES  = 4;
  localparam int unsigned SETTLE_WRAPS = 2;
  localparam int unsigned WIN_LOG2     = 4;
  localparam int unsigned ERR_W        = 2;
  localparam int unsigned ERR_THRESH   = 3;

  logic                clk = 1'b0;
  logic                reset, start, abort, sym_clk_ena, lfsr_wrap, sym_correct, sym_error;
  logic                load_data, clear_accumulator, busy, measuring, done, err_sat, proto_err;
  logic [WIN_LOG2:0]   sym_count;
  logic [ERR_W-1:0]    err_count;
`ifdef BER_THRESH_EN
  logic                ber_pass;
`endif

  typedef struct {
    int unsigned sym;
    int unsigned err;
    logic        sat;
    logic        proto;
    logic        pass;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  ber_test_controller #(
    .LOAD_CYCLES  (LOAD_CYCLES),
    .SETTLE_WRAPS (SETTLE_WRAPS),
    .WIN_LOG2     (WIN_LOG2),
    .ERR_W        (ERR_W),
    .ERR_THRESH   (ERR_THRESH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .sym_clk_ena       (sym_clk_ena),
    .lfsr_wrap         (lfsr_wrap),
    .sym_correct       (sym_correct),
    .sym_error         (sym_error),
    .load_data         (load_data),
    .clear_accumulator (clear_accumulator),
    .busy              (busy),
    .measuring         (measuring),
    .done              (done),
    .sym_count         (sym_count),
    .err_count         (err_count),
    .err_sat           (err_sat),
    .proto_err         (proto_err)
`ifdef BER_THRESH_EN
    ,
    .ber_pass          (ber_pass)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        e = sb.pop_front();
        chk("res_sym_count", 32'(sym_count), e.sym);
        chk("res_err_count", 32'(err_count), e.err);
        chk("res_err_sat", 32'(err_sat), 32'(e.sat));
        chk("res_proto_err", 32'(proto_err), 32'(e.proto));
`ifdef BER_THRESH_EN
        chk("res_ber_pass", 32'(ber_pass), 32'(e.pass));
`endif
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_wrap();
    lfsr_wrap = 1'b1;
    @(negedge clk);
    lfsr_wrap = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_strobes"}, 32'({load_data, clear_accumulator, busy, measuring, done, err_sat, proto_err}), 0);
    chk({name, "_sym_count"}, 32'(sym_count), 0);
    chk({name, "_err_count"}, 32'(err_count), 0);
`ifdef BER_THRESH_EN
    chk({name, "_ber_pass"}, 32'(ber_pass), 0);
`endif
  endtask

  // Start (from IDLE or a rising start in DONE) and run through to MEASURE
  task automatic begin_test(input bit hold);
    start = 1'b1;
    @(negedge clk);
    chk("start_busy", 32'(busy), 1);
    chk("start_load", 32'(load_data), 1);
`ifdef BER_THRESH_EN
    chk("start_ber_pass", 32'(ber_pass), 0);
`endif
    if (!hold) start = 1'b0;
    idle(5);
    pulse_wrap();
    chk("wrap1_clear", 32'(clear_accumulator), 1);
    chk("wrap1_meas", 32'(measuring), 0);
    idle(1);
    pulse_wrap();
    chk("entry_meas", 32'(measuring), 1);
    chk("entry_sym", 32'(sym_count), 0);
    chk("entry_err", 32'(err_count), 0);
    chk("entry_sat", 32'(err_sat), 0);
    chk("entry_proto", 32'(proto_err), 0);
  endtask

  // 16 enabled symbols with occasional idle gaps; pm marks correct==error
  task automatic run_window(input logic [15:0] em, input logic [15:0] pm);
    for (int i = 0; i < 16; i++) begin
      if (i % 5 == 4) idle(1);
      sym_clk_ena = 1'b1;
      sym_error   = em[i];
      sym_correct = pm[i] ? em[i] : !em[i];
      @(negedge clk);
      sym_clk_ena = 1'b0;
      sym_error   = 1'b0;
      sym_correct = 1'b0;
      if (i == 14) begin
        chk("pre_end_done", 32'(done), 0);
        chk("pre_end_sym", 32'(sym_count), 15);
      end
    end
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_meas", 32'(measuring), 0);
    idle(1);
    chk("done_pulse_len", 32'(done), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; sym_clk_ena = 1'b0;
    lfsr_wrap = 1'b0; sym_correct = 1'b0; sym_error = 1'b0;
    idle(3);
    chk_all_zero("reset");
    reset = 1'b0;
    idle(2);

    // Load strobe length and first clear pulse
    start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      chk($sformatf("load_data_c%0d", k), 32'(load_data), (k <= 4) ? 1 : 0);
      chk($sformatf("load_clear_c%0d", k), 32'(clear_accumulator), (k == 5) ? 1 : 0);
      chk($sformatf("load_busy_c%0d", k), 32'(busy), 1);
    end

    // Window with 3 errors
    pulse_wrap();
    chk("t2_wrap1_clear", 32'(clear_accumulator), 1);
    chk("t2_wrap1_meas", 32'(measuring), 0);
    idle(1);
    pulse_wrap();
    chk("t2_entry_meas", 32'(measuring), 1);
    sb.push_back('{sym: 16, err: 3, sat: 1'b0, proto: 1'b0, pass: 1'b1});
    run_window(16'h8084, 16'h0000);
    sym_clk_ena = 1'b1; sym_correct = 1'b0; sym_error = 1'b1;
    @(negedge clk);
    sym_clk_ena = 1'b0; sym_error = 1'b0;
    chk("done_hold_sym", 32'(sym_count), 16);
    chk("done_hold_err", 32'(err_count), 3);

    // Protocol error: both flags high on symbol 3, both low on symbol 9
    sb.push_back('{sym: 16, err: 2, sat: 1'b0, proto: 1'b1, pass: 1'b1});
    begin_test(1'b0);
    run_window(16'h1008, 16'h0208);
    chk("proto_sticky", 32'(proto_err), 1);

    // Saturation with start held high through the run
    sb.push_back('{sym: 16, err: 3, sat: 1'b1, proto: 1'b0, pass: 1'b0});
    begin_test(1'b1);
    run_window(16'h2113, 16'h0000);
    idle(4);
    chk("held_start_busy", 32'(busy), 0);
    chk("held_start_sym", 32'(sym_count), 16);
    chk("held_start_sat", 32'(err_sat), 1);
    start = 1'b0;
    idle(1);

    // Abort after 7 symbols
    begin_test(1'b0);
    for (int i = 0; i < 7; i++) begin
      sym_clk_ena = 1'b1;
      sym_error   = (i == 2);
      sym_correct = (i != 2);
      @(negedge clk);
    end
    sym_clk_ena = 1'b0; sym_error = 1'b0; sym_correct = 1'b0;
    chk("pre_abort_sym", 32'(sym_count), 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_meas", 32'(measuring), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_err", 32'(err_count), 1);
    idle(3);
    chk("abort_hold_sym", 32'(sym_count), 7);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("start_abort_busy", 32'(busy), 0);
    chk("start_abort_load", 32'(load_data), 0);
    start = 1'b0; abort = 1'b0;
    idle(2);
    chk("start_abort_idle", 32'(busy), 0);

    // Wrap on the LOAD exit edge gives one clear pulse and is not counted
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(3);
    lfsr_wrap = 1'b1;
    @(negedge clk);
    lfsr_wrap = 1'b0;
    chk("coinc_clear", 32'(clear_accumulator), 1);
    chk("coinc_load", 32'(load_data), 0);
    idle(1);
    chk("coinc_clear_after1", 32'(clear_accumulator), 0);
    idle(1);
    chk("coinc_clear_after2", 32'(clear_accumulator), 0);
    pulse_wrap();
    chk("coinc_not_counted", 32'(measuring), 0);
    chk("settle_busy", 32'(busy), 1);

    // Reset mid-SETTLE
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("mid_reset");
    idle(3);
    chk("post_reset_busy", 32'(busy), 0);

    idle(2);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
